scaled_event_counter: RTL and testbench

Parametrised prescaled event counter with selectable fast/slow rate, up/down counting, synchronous load, and terminal-count flags. It generalises the fixed 8-bit divider/counter: both rates, both widths and the count direction are now configurable, and it adds `tick` and `wrap` strobes for downstream logic. It sits between the board clock and display/timing logic, which consume `clkout`, `tick` and `counter`.

---
 rtl/scaled_event_counter.sv | 113 +++++++++++
 tb/tb_scaled_event_counter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scaled_event_counter.sv
`default_nettype none
// ============================================================================
//  Module   : scaled_event_counter
//  Purpose  : Prescaled up/down event counter. A prescaler divides clkin by
//             a selectable fast/slow ratio. Each prescaler wrap produces a
//             tick, toggles clkout and steps the main counter. A wrap strobe
//             flags a main-counter rollover.
//  Revision : 1.0  initial release
// ============================================================================
module scaled_event_counter #(
   parameter int WIDTH    = 8,
   parameter int PRE_W    = 7,
   parameter int DIV_SLOW = 100,
   parameter int DIV_FAST = 4
) (
   input  logic             clkin,
   input  logic             reset,
   input  logic             fast,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             clkout,
   output logic             tick,
   output logic             wrap,
   output logic [WIDTH-1:0] counter,
   output logic [PRE_W-1:0] clkcounter
);

   // Terminal prescaler values (DIV-1) for each rate, plus unit increments
   localparam logic [PRE_W-1:0] c_last_slow = PRE_W'(DIV_SLOW - 1);
   localparam logic [PRE_W-1:0] c_last_fast = PRE_W'(DIV_FAST - 1);
   localparam logic [PRE_W-1:0] c_pre_one   = PRE_W'(1);
   localparam logic [WIDTH-1:0] c_cnt_one   = WIDTH'(1);

   logic             r_fast_q;        // registered rate select
   logic [PRE_W-1:0] w_last;          // terminal prescaler value at current rate
   logic             w_rate_chg;      // requested rate differs from active rate
   logic             w_period_end;    // this edge is a prescaler wrap event
   logic             w_advance;       // this edge increments the prescaler
   logic [WIDTH-1:0] w_counter_next;  // main counter after one step
   logic             w_rollover;      // stepping would cross the 0/all-ones seam

   // Decode what this edge does; load outranks a rate change, which outranks counting
   always_comb begin
      w_last       = r_fast_q ? c_last_fast : c_last_slow;
      w_rate_chg   = (fast != r_fast_q);
      w_period_end = 1'b0;
      w_advance    = 1'b0;
      if (!load && !w_rate_chg && enable) begin
         // ">=" rather than "==" so a stray value can never count past the period
         if (clkcounter >= w_last) begin
            w_period_end = 1'b1;
         end else begin
            w_advance = 1'b1;
         end
      end
   end

   // Next main-counter value and rollover detection for the current direction
   always_comb begin
      w_counter_next = counter;
      w_rollover     = 1'b0;
      if (up) begin
         w_counter_next = counter + c_cnt_one;
         w_rollover     = &counter;
      end else begin
         w_counter_next = counter - c_cnt_one;
         w_rollover     = (counter == '0);
      end
   end

   // Prescaler and active-rate register; load and rate change both restart the period
   always_ff @(posedge clkin or negedge reset) begin
      if (!reset) begin
         r_fast_q   <= 1'b0;
         clkcounter <= '0;
      end else if (load || w_rate_chg) begin
         r_fast_q   <= fast;
         clkcounter <= '0;
      end else if (w_period_end) begin
         clkcounter <= '0;
      end else if (w_advance) begin
         clkcounter <= clkcounter + c_pre_one;
      end
   end

   // Main counter and divided clock; load writes the counter but leaves clkout alone
   always_ff @(posedge clkin or negedge reset) begin
      if (!reset) begin
         counter <= '0;
         clkout  <= 1'b0;
      end else if (load) begin
         counter <= load_val;
      end else if (w_period_end) begin
         counter <= w_counter_next;
         clkout  <= ~clkout;
      end
   end

   // Single-cycle strobes aligned with the edge that updates counter and clkout
   always_ff @(posedge clkin or negedge reset) begin
      if (!reset) begin
         tick <= 1'b0;
         wrap <= 1'b0;
      end else begin
         tick <= w_period_end;
         wrap <= w_period_end & w_rollover;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_scaled_event_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scaled_event_counter
//  Purpose  : Self-checking bench for scaled_event_counter. A cycle model
//             pushes expected outputs at each rising edge; they are popped
//             and compared on the following falling edge. Directed checks
//             cover the rate, wrap, freeze, load and reset scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_scaled_event_counter;

   localparam int WIDTH    = 8;
   localparam int PRE_W    = 7;
   localparam int DIV_SLOW = 100;
   localparam int DIV_FAST = 4;

   logic             clkin = 1'b0;
   logic             reset;
   logic             fast;
   logic             enable;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             clkout;
   logic             tick;
   logic             wrap;
   logic [WIDTH-1:0] counter;
   logic [PRE_W-1:0] clkcounter;

   int n_total = 0;
   int n_bad   = 0;

   typedef struct {
      logic             clkout;
      logic             tick;
      logic             wrap;
      logic [WIDTH-1:0] counter;
      logic [PRE_W-1:0] cc;
   } exp_t;

   exp_t sb_q[$];

   // Reference model state
   bit m_fq;
   bit m_clk;
   bit m_tick;
   bit m_wrap;
   int m_cc;
   int m_cnt;

   scaled_event_counter #(
      .WIDTH   (WIDTH),
      .PRE_W   (PRE_W),
      .DIV_SLOW(DIV_SLOW),
      .DIV_FAST(DIV_FAST)
   ) dut (
      .clkin     (clkin),
      .reset     (reset),
      .fast      (fast),
      .enable    (enable),
      .up        (up),
      .load      (load),
      .load_val  (load_val),
      .clkout    (clkout),
      .tick      (tick),
      .wrap      (wrap),
      .counter   (counter),
      .clkcounter(clkcounter)
   );

   // Free-running clock
   always #5 clkin = ~clkin;

   // Hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_fq   = 1'b0;
      m_clk  = 1'b0;
      m_tick = 1'b0;
      m_wrap = 1'b0;
      m_cc   = 0;
      m_cnt  = 0;
   endtask

   task automatic model_edge();
      int div;
      div    = m_fq ? DIV_FAST : DIV_SLOW;
      m_tick = 1'b0;
      m_wrap = 1'b0;
      if (load) begin
         m_cnt = int'(load_val);
         m_cc  = 0;
         m_fq  = fast;
      end else if (fast != m_fq) begin
         m_cc = 0;
         m_fq = fast;
      end else if (enable) begin
         if (m_cc == div - 1) begin
            m_cc   = 0;
            m_clk  = ~m_clk;
            m_tick = 1'b1;
            if (up) begin
               m_wrap = (m_cnt == 255);
               m_cnt  = (m_cnt + 1) % 256;
            end else begin
               m_wrap = (m_cnt == 0);
               m_cnt  = (m_cnt + 255) % 256;
            end
         end else begin
            m_cc = m_cc + 1;
         end
      end
   endtask

   // One clock: model at the rising edge, compare at the falling edge
   task automatic step();
      exp_t e;
      @(posedge clkin);
      if (!reset) model_reset();
      else        model_edge();
      e.clkout  = m_clk;
      e.tick    = m_tick;
      e.wrap    = m_wrap;
      e.counter = WIDTH'(m_cnt);
      e.cc      = PRE_W'(m_cc);
      sb_q.push_back(e);
      @(negedge clkin);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("sb_clkout",  32'(clkout),     32'(e.clkout));
         check("sb_tick",    32'(tick),       32'(e.tick));
         check("sb_wrap",    32'(wrap),       32'(e.wrap));
         check("sb_counter", 32'(counter),    32'(e.counter));
         check("sb_cc",      32'(clkcounter), 32'(e.cc));
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Assert reset between edges and confirm outputs clear without a clock edge
   task automatic apply_reset();
      reset = 1'b0;
      model_reset();
      #1;
      check("rst_clkout",  32'(clkout),     32'd0);
      check("rst_tick",    32'(tick),       32'd0);
      check("rst_wrap",    32'(wrap),       32'd0);
      check("rst_counter", 32'(counter),    32'd0);
      check("rst_cc",      32'(clkcounter), 32'd0);
   endtask

   initial begin
      reset    = 1'b1;
      fast     = 1'b0;
      enable   = 1'b0;
      up       = 1'b1;
      load     = 1'b0;
      load_val = '0;
      model_reset();

      // Power-on reset
      @(negedge clkin);
      apply_reset();
      run(2);
      reset = 1'b1;

      // Slow rate: ticks every 100 edges, clkout half period 100
      enable = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         step();
         if (k % 100 == 0) begin
            check("slow_tick", 32'(tick),    32'd1);
            check("slow_cnt",  32'(counter), 32'(k / 100));
         end
         if (k == 99)  check("slow_notick99", 32'(tick),   32'd0);
         if (k == 100) check("slow_clk100",   32'(clkout), 32'd1);
         if (k == 199) check("slow_clk199",   32'(clkout), 32'd1);
         if (k == 200) check("slow_clk200",   32'(clkout), 32'd0);
         if (k == 299) check("slow_clk299",   32'(clkout), 32'd0);
      end

      // Fast switch at edge 37
      @(negedge clkin);
      apply_reset();
      run(1);
      reset = 1'b1;
      run(36);
      fast = 1'b1;
      step();
      check("fs_cc",   32'(clkcounter), 32'd0);
      check("fs_tick", 32'(tick),       32'd0);
      for (int k = 38; k <= 49; k++) begin
         step();
         if (k == 41 || k == 45 || k == 49) begin
            check("fs_tick_n", 32'(tick),    32'd1);
            check("fs_cnt",    32'(counter), 32'((k - 37) / 4));
         end
      end

      // Wrap in both directions at the fast rate
      load     = 1'b1;
      load_val = 8'hFE;
      up       = 1'b1;
      step();
      load = 1'b0;
      check("wr_load", 32'(counter), 32'hFE);
      run(3); step();
      check("wr_t1_cnt",  32'(counter), 32'hFF);
      check("wr_t1_wrap", 32'(wrap),    32'd0);
      run(3); step();
      check("wr_t2_tick", 32'(tick),    32'd1);
      check("wr_t2_cnt",  32'(counter), 32'h00);
      check("wr_t2_wrap", 32'(wrap),    32'd1);
      up = 1'b0;
      run(3); step();
      check("wr_dn1_cnt",  32'(counter), 32'hFF);
      check("wr_dn1_wrap", 32'(wrap),    32'd1);
      run(3); step();
      check("wr_dn2_tick", 32'(tick),    32'd1);
      check("wr_dn2_cnt",  32'(counter), 32'hFE);
      check("wr_dn2_wrap", 32'(wrap),    32'd0);

      // Freeze with enable low at clkcounter = 50
      @(negedge clkin);
      apply_reset();
      fast = 1'b0;
      up   = 1'b1;
      run(1);
      reset = 1'b1;
      run(50);
      check("fz_cc50", 32'(clkcounter), 32'd50);
      enable = 1'b0;
      run(20);
      check("fz_hold_cc",  32'(clkcounter), 32'd50);
      check("fz_hold_cnt", 32'(counter),    32'd0);
      enable = 1'b1;
      run(49);
      check("fz_notick", 32'(tick),       32'd0);
      check("fz_cc99",   32'(clkcounter), 32'd99);
      step();
      check("fz_tick", 32'(tick),    32'd1);
      check("fz_cnt",  32'(counter), 32'd1);

      // Load coinciding with a rate change
      load     = 1'b1;
      load_val = 8'h55;
      fast     = 1'b1;
      step();
      load = 1'b0;
      check("lr_cnt",  32'(counter),    32'h55);
      check("lr_cc",   32'(clkcounter), 32'd0);
      check("lr_tick", 32'(tick),       32'd0);
      run(3);
      check("lr_notick", 32'(tick), 32'd0);
      step();
      check("lr_tick4", 32'(tick),    32'd1);
      check("lr_cnt4",  32'(counter), 32'h56);

      // Reach counter = 0x33 with clkout high, then reset between edges
      for (int a = 0; a < 3 && !(m_clk == 1'b1 && m_cnt == 8'h33); a++) begin
         load     = 1'b1;
         load_val = 8'h32;
         step();
         load = 1'b0;
         run(4);
      end
      check("mr_pre_cnt", 32'(counter), 32'h33);
      check("mr_pre_clk", 32'(clkout),  32'd1);
      #2;
      apply_reset();
      run(1);
      fast  = 1'b0;
      reset = 1'b1;
      run(99);
      check("mr_notick", 32'(tick), 32'd0);
      step();
      check("mr_tick", 32'(tick),    32'd1);
      check("mr_cnt",  32'(counter), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
